// File: rtl/hazard_scheduler.sv
// Hazard scheduler for a classic five-stage pipeline.
// Resolves taken branches, load-use hazards and multi-cycle mul/div occupancy
// of EX. It drives the pipeline-register write/flush/bubble controls and keeps
// a saturating count of front-end stall cycles.
module hazard_scheduler #(
   parameter int MD_LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic [4:0]  IE_rt,
   input  logic        IE_memread,
   input  logic        IE_md_start,
   input  logic        IE_branch_taken,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        IF_ID_flush,
   output logic        ID_EX_write,
   output logic        ID_EX_bubble,
   output logic        EX_MEM_bubble,
   output logic        md_busy,
   output logic        md_done,
   output logic [15:0] stall_cnt
);

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   // The start cycle counts as the first stall cycle and the done cycle as the
   // last, so the counter covers the remaining MD_LATENCY-2 cycles between them.
   localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 2);

   state_t     state;
   logic [3:0] md_cnt;
   logic       load_use;

   assign load_use = IE_memread && (IE_rt != 5'd0) &&
                     ((IE_rt == ID_rs) || (IE_rt == ID_rt));

   // Pipeline controls act in the same cycle the hazard is seen, so they are
   // decoded combinationally from the current state and the EX/ID fields.
   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_bubble = 1'b0;
      md_busy       = 1'b0;
      md_done       = 1'b0;
      case (state)
         RUN: begin
            if (IE_branch_taken) begin
               IF_ID_flush  = 1'b1;
               ID_EX_bubble = 1'b1;
            end else if (IE_md_start) begin
               pc_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_bubble = 1'b1;
               md_busy       = 1'b1;
            end else if (load_use) begin
               pc_write     = 1'b0;
               IF_ID_write  = 1'b0;
               ID_EX_bubble = 1'b1;
            end
         end
         MD_BUSY: begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
            md_busy     = 1'b1;
            if (md_cnt == 4'd0) begin
               md_done = 1'b1;
            end else begin
               EX_MEM_bubble = 1'b1;
            end
         end
         default: begin
            pc_write = 1'b1;
         end
      endcase
   end

   // Mul/div occupancy FSM: a taken branch squashes the start, and a start seen
   // while already busy is ignored so the count is never reloaded.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= RUN;
         md_cnt <= 4'd0;
      end else begin
         case (state)
            RUN: begin
               if (!IE_branch_taken && IE_md_start) begin
                  state  <= MD_BUSY;
                  md_cnt <= MD_RELOAD;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 4'd0) begin
                  state <= RUN;
               end else begin
                  md_cnt <= md_cnt - 4'd1;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Count every cycle the PC is held, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= 16'd0;
      end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: one instance at the default mul/div latency and
// one at the minimum latency of 2, both fed the same stimulus and compared
// against a cycle-level reference model that tracks remaining mul/div cycles.
module tb_hazard_scheduler;

   logic       clk_i;
   logic       rst_i;
   logic [4:0] ID_rs;
   logic [4:0] ID_rt;
   logic [4:0] IE_rt;
   logic       IE_memread;
   logic       IE_md_start;
   logic       IE_branch_taken;

   logic        pc_a, ifw_a, iff_a, idw_a, idb_a, exb_a, busy_a, done_a;
   logic [15:0] cnt_a;
   logic        pc_b, ifw_b, iff_b, idw_b, idb_b, exb_b, busy_b, done_b;
   logic [15:0] cnt_b;

   int checks = 0;
   int errors = 0;

   int md_left [2];
   int scnt    [2];
   int lat     [2];

   hazard_scheduler #(.MD_LATENCY(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ID_rs(ID_rs), .ID_rt(ID_rt), .IE_rt(IE_rt),
      .IE_memread(IE_memread), .IE_md_start(IE_md_start),
      .IE_branch_taken(IE_branch_taken),
      .pc_write(pc_a), .IF_ID_write(ifw_a), .IF_ID_flush(iff_a),
      .ID_EX_write(idw_a), .ID_EX_bubble(idb_a), .EX_MEM_bubble(exb_a),
      .md_busy(busy_a), .md_done(done_a), .stall_cnt(cnt_a)
   );

   hazard_scheduler #(.MD_LATENCY(2)) dut2 (
      .clk_i(clk_i), .rst_i(rst_i), .ID_rs(ID_rs), .ID_rt(ID_rt), .IE_rt(IE_rt),
      .IE_memread(IE_memread), .IE_md_start(IE_md_start),
      .IE_branch_taken(IE_branch_taken),
      .pc_write(pc_b), .IF_ID_write(ifw_b), .IF_ID_flush(iff_b),
      .ID_EX_write(idw_b), .ID_EX_bubble(idb_b), .EX_MEM_bubble(exb_b),
      .md_busy(busy_b), .md_done(done_b), .stall_cnt(cnt_b)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Observed controls packed as {pc,ifw,iff,idw,idb,exb,busy,done}.
   function automatic logic [7:0] dut_vec(input int k);
      if (k == 0) return {pc_a, ifw_a, iff_a, idw_a, idb_a, exb_a, busy_a, done_a};
      return {pc_b, ifw_b, iff_b, idw_b, idb_b, exb_b, busy_b, done_b};
   endfunction

   function automatic logic [15:0] dut_cnt(input int k);
      return (k == 0) ? cnt_a : cnt_b;
   endfunction

   // Reference model: expected controls from remaining mul/div cycles and inputs.
   function automatic logic [7:0] exp_out(input int k);
      logic lu;
      lu = IE_memread && (IE_rt != 0) && ((IE_rt == ID_rs) || (IE_rt == ID_rt));
      if (md_left[k] > 0)
         return {5'b00000, (md_left[k] != 1), 1'b1, (md_left[k] == 1)};
      if (IE_branch_taken) return 8'b11111000;
      if (IE_md_start)     return 8'b00000110;
      if (lu)              return 8'b00011000;
      return 8'b11010000;
   endfunction

   // Reference model: state after the coming rising edge.
   task automatic model_advance();
      for (int k = 0; k < 2; k++) begin
         logic [7:0] e;
         e = exp_out(k);
         if (!e[7] && scnt[k] < 65535) scnt[k]++;
         if (md_left[k] > 0) md_left[k]--;
         else if (!IE_branch_taken && IE_md_start) md_left[k] = lat[k] - 1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         md_left[k] = 0;
         scnt[k]    = 0;
      end
   endtask

   task automatic set_inputs(input logic br, input logic md, input logic mr,
                             input logic [4:0] rt_ex, input logic [4:0] rs,
                             input logic [4:0] rt);
      IE_branch_taken = br;
      IE_md_start     = md;
      IE_memread      = mr;
      IE_rt           = rt_ex;
      ID_rs           = rs;
      ID_rt           = rt;
   endtask

   task automatic do_reset();
      set_inputs(0, 0, 0, 0, 0, 0);
      rst_i = 1'b1;
      model_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   // Reset state, including combinational response to inputs while in reset.
   task automatic test_reset();
      set_inputs(0, 0, 0, 0, 0, 0);
      rst_i = 1'b1;
      model_reset();
      #2;
      checks++;
      if (dut_vec(0) !== 8'b11010000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got %b expected %b", dut_vec(0), 8'b11010000);
      end
      checks++;
      if (cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_cnt got %h expected 0000", cnt_a);
      end
      set_inputs(0, 0, 1, 5'd7, 5'd7, 5'd0);
      #1;
      checks++;
      if (dut_vec(0) !== 8'b00011000) begin
         errors++;
         $display("[TB] FAIL reset_loaduse got %b expected %b", dut_vec(0), 8'b00011000);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_hold_cnt got %h expected 0000", cnt_a);
      end
      rst_i = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 0);
   endtask

   // Load-use on rs stalls one cycle; the same pattern on r0 does nothing.
   task automatic test_load_use();
      do_reset();
      set_inputs(0, 0, 1, 5'd5, 5'd5, 5'd9);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b00011000) begin
         errors++;
         $display("[TB] FAIL loaduse_ctrl got %b expected %b", dut_vec(0), 8'b00011000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(0, 0, 0, 5'd5, 5'd5, 5'd9);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b11010000 || cnt_a !== 16'd1) begin
         errors++;
         $display("[TB] FAIL loaduse_after got %b/%h expected %b/0001", dut_vec(0), cnt_a, 8'b11010000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(0, 0, 1, 5'd0, 5'd0, 5'd0);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b11010000) begin
         errors++;
         $display("[TB] FAIL loaduse_r0 got %b expected %b", dut_vec(0), 8'b11010000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(0, 0, 1, 5'd12, 5'd3, 5'd12);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b00011000 || cnt_a !== 16'd1) begin
         errors++;
         $display("[TB] FAIL loaduse_rt got %b/%h expected %b/0001", dut_vec(0), cnt_a, 8'b00011000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(0, 0, 0, 0, 0, 0);
   endtask

   // Four-cycle mul/div: start held high throughout must not re-trigger.
   task automatic test_muldiv();
      logic [7:0] exp_seq [6];
      exp_seq = '{8'b00000110, 8'b00000110, 8'b00000110, 8'b00000011,
                  8'b00000110, 8'b00000110};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         set_inputs(0, (c == 0) || (c == 4), 0, 0, 0, 0);
         if (c == 1) IE_md_start = 1'b1;
         @(negedge clk_i);
         checks++;
         if (dut_vec(0) !== exp_seq[c] || cnt_a !== 16'(c)) begin
            errors++;
            $display("[TB] FAIL muldiv_c%0d got %b/%h expected %b/%h", c, dut_vec(0), cnt_a, exp_seq[c], 16'(c));
         end
         model_advance();
         @(posedge clk_i);
         #1;
      end
      do_reset();
      for (int c = 0; c < 5; c++) begin
         set_inputs(0, c == 0, 0, 0, 0, 0);
         @(negedge clk_i);
         checks++;
         if (dut_vec(0) !== ((c == 4) ? 8'b11010000 : exp_seq[c]) || cnt_a !== 16'(c)) begin
            errors++;
            $display("[TB] FAIL muldiv_pulse_c%0d got %b/%h expected %b/%h", c, dut_vec(0), cnt_a,
                     (c == 4) ? 8'b11010000 : exp_seq[c], 16'(c));
         end
         model_advance();
         @(posedge clk_i);
         #1;
      end
   endtask

   // Minimum latency: two stall cycles, done on the second.
   task automatic test_md_lat2();
      logic [7:0] exp_seq [3];
      exp_seq = '{8'b00000110, 8'b00000011, 8'b11010000};
      do_reset();
      for (int c = 0; c < 3; c++) begin
         set_inputs(0, c == 0, 0, 0, 0, 0);
         @(negedge clk_i);
         checks++;
         if (dut_vec(1) !== exp_seq[c] || cnt_b !== 16'(c)) begin
            errors++;
            $display("[TB] FAIL lat2_c%0d got %b/%h expected %b/%h", c, dut_vec(1), cnt_b, exp_seq[c], 16'(c));
         end
         model_advance();
         @(posedge clk_i);
         #1;
      end
   endtask

   // A taken branch outranks both load-use and mul/div start.
   task automatic test_branch_priority();
      do_reset();
      set_inputs(1, 0, 1, 5'd5, 5'd5, 5'd0);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b11111000) begin
         errors++;
         $display("[TB] FAIL branch_lu got %b expected %b", dut_vec(0), 8'b11111000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(1, 1, 0, 0, 0, 0);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b11111000 || cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL branch_md got %b/%h expected %b/0000", dut_vec(0), cnt_a, 8'b11111000);
      end
      model_advance();
      @(posedge clk_i);
      #1;
      set_inputs(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checks++;
      if (dut_vec(0) !== 8'b11010000 || cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL branch_after got %b/%h expected %b/0000", dut_vec(0), cnt_a, 8'b11010000);
      end
   endtask

   // Reset in the middle of a mul/div aborts it without a done pulse.
   task automatic test_reset_mid_md();
      int seen_done;
      do_reset();
      set_inputs(0, 1, 0, 0, 0, 0);
      model_advance();
      @(posedge clk_i);
      #1;
      IE_md_start = 1'b0;
      model_advance();
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      model_reset();
      #1;
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid busy/done/cnt got %b/%b/%h expected 0/0/0000", busy_a, done_a, cnt_a);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         if (done_a || busy_a) seen_done++;
         model_advance();
      end
      checks++;
      if (seen_done !== 0 || cnt_a !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_after busy/done cycles %0d cnt %h expected 0/0000", seen_done, cnt_a);
      end
   endtask

   // Randomised traffic compared cycle by cycle against the model.
   task automatic test_random();
      do_reset();
      for (int c = 0; c < 300; c++) begin
         set_inputs($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         @(negedge clk_i);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== exp_out(k) || dut_cnt(k) !== 16'(scnt[k])) begin
               errors++;
               $display("[TB] FAIL random_c%0d_inst%0d got %b/%h expected %b/%h", c, k,
                        dut_vec(k), dut_cnt(k), exp_out(k), 16'(scnt[k]));
            end
         end
         model_advance();
         @(posedge clk_i);
         #1;
      end
      set_inputs(0, 0, 0, 0, 0, 0);
   endtask

   // Continuous load-use stall long enough to saturate the counter.
   task automatic test_saturation();
      do_reset();
      set_inputs(0, 0, 1, 5'd5, 5'd5, 5'd0);
      for (int c = 0; c < 65540; c++) begin
         model_advance();
         @(posedge clk_i);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (dut_cnt(k) !== 16'hFFFF || scnt[k] != 65535) begin
            errors++;
            $display("[TB] FAIL saturate_inst%0d got %h expected ffff", k, dut_cnt(k));
         end
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (cnt_a !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL saturate_hold got %h expected ffff", cnt_a);
      end
      set_inputs(0, 0, 0, 0, 0, 0);
   endtask

   // Test sequence.
   initial begin
      lat[0] = 4;
      lat[1] = 2;
      rst_i  = 1'b1;
      set_inputs(0, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_load_use();
      test_muldiv();
      test_md_lat2();
      test_branch_priority();
      test_reset_mid_md();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter MD_LATENCY, default 4, total EX-stage occupancy in cycles of a multi-cycle mul/div; legal range 2..16.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 ID_rs  input  5  rs field of instruction in ID.
REQ-005 ID_rt  input  5  rt field of instruction in ID.
REQ-006 IE_rt  input  5  rt (load destination) of instruction in EX.
REQ-007 IE_memread  input  1  instruction in EX is a load.
REQ-008 IE_md_start  input  1  instruction in EX is a multi-cycle mul/div; valid only in RUN.
REQ-009 IE_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-010 pc_write  output  1  1 = PC may update.
REQ-011 IF_ID_write  output  1  1 = IF/ID register may load.
REQ-012 IF_ID_flush  output  1  1 = IF/ID loads a NOP.
REQ-013 ID_EX_write  output  1  1 = ID/EX register may load.
REQ-014 ID_EX_bubble  output  1  1 = ID/EX loads a NOP (control bits zeroed).
REQ-015 EX_MEM_bubble  output  1  1 = EX/MEM loads a NOP.
REQ-016 md_busy  output  1  1 while mul/div occupies EX.
REQ-017 md_done  output  1  single-cycle pulse on final mul/div cycle.
REQ-018 stall_cnt  output  16  saturating count of cycles with pc_write=0.

Function
REQ-019 FSM has exactly two states: RUN and MD_BUSY; plus a 4-bit down-counter md_cnt and the 16-bit stall_cnt register.
REQ-020 Pipeline-control outputs are combinational from current state and inputs (same-cycle effect); stall_cnt, state, md_cnt are registered.
REQ-021 Load-use hazard = IE_memread && IE_rt!=0 && (IE_rt==ID_rs || IE_rt==ID_rt).
REQ-022 RUN, no event: pc_write=1, IF_ID_write=1, ID_EX_write=1, all flush/bubble=0, md_busy=0, md_done=0.
REQ-023 RUN priority, highest first: IE_branch_taken, IE_md_start, load-use hazard.
REQ-024 RUN + IE_branch_taken: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1; IE_md_start and load-use ignored that cycle; state stays RUN.
REQ-025 RUN + IE_md_start (no branch): pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1, md_busy=1; next state MD_BUSY, md_cnt loads MD_LATENCY-2.
REQ-026 RUN + load-use only: pc_write=0, IF_ID_write=0, ID_EX_bubble=1; state stays RUN (one-cycle stall, hazard clears as load advances).
REQ-027 MD_BUSY: pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1, md_busy=1; all other inputs ignored.
REQ-028 MD_BUSY with md_cnt!=0: md_cnt decrements by 1, stay MD_BUSY.
REQ-029 MD_BUSY with md_cnt==0: md_done=1, EX_MEM_bubble=0 (result passes to EX/MEM), next state RUN.
REQ-030 Total stall for a mul/div is exactly MD_LATENCY cycles, counting the IE_md_start cycle; md_done asserted on the last of them.
REQ-031 stall_cnt increments by 1 each cycle pc_write=0; holds at 16'hFFFF (no wrap).
REQ-032 IE_md_start asserted in MD_BUSY has no effect (no re-trigger, no counter reload).

Reset
REQ-033 rst_i=1 forces state=RUN, md_cnt=0, stall_cnt=0 immediately, independent of clk_i.
REQ-034 During and after reset, outputs take RUN/no-event values per REQ-022, subject to current combinational inputs.
REQ-035 Reset asserted mid mul/div aborts it: no md_done pulse, RUN on release.

Verification
REQ-036 Load-use: IE_memread=1, IE_rt=5, ID_rs=5 -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 one cycle; stall_cnt 0->1; IE_rt=0 same stimulus -> no stall.
REQ-037 Mul/div, MD_LATENCY=4: IE_md_start pulse one cycle -> pc_write=0 for cycles 0..3, md_done=1 only in cycle 3, pc_write=1 cycle 4, stall_cnt=4.
REQ-038 Branch plus load-use same cycle: IE_branch_taken=1, load-use true -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; stall_cnt unchanged.
REQ-039 Reset mid mul/div: rst_i at cycle 2 of 4 -> md_busy=0 immediately, stall_cnt=0, md_done never pulses.
REQ-040 Saturation: force 65,540 consecutive stall cycles -> stall_cnt reaches 16'hFFFF and holds.
REQ-041 MD_LATENCY=2 boundary: IE_md_start -> exactly 2 stall cycles, md_done on second.
